// File: rtl/cache_pkg.sv
// Shared types for the cache-to-memory bridge: address/data defaults,
// bridge FSM states and the write-buffer entry layout.
package cache_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int WOFF   = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_MEM,
    WR_MEM,
    RSP
  } state_t;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-buffer FIFO with a parallel word-address search that returns the
// newest matching entry, so refill reads see the latest buffered store.
module wb_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  input  logic [AW_DEF-1:WOFF]   lookup,
  output logic                   hit,
  output logic [DW_DEF-1:0]      hit_data,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [PW-1:0]   idx;

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only slots inside the live window are ever searched.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Scan oldest to newest so the last match standing is the newest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((i < int'(count)) && (mem[idx].addr[AW_DEF-1:WOFF] == lookup)) begin
        hit      = 1'b1;
        hit_data = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/cache_mem_bridge.sv
// Bridge between the cache controller and main memory: buffers write-through
// stores, drains them in the background and services refill reads.
module cache_mem_bridge
  import cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_empty
);

  state_t        state;
  logic          rd_busy;
  logic          rd_hit;
  logic [AW-1:0] rd_addr;
  logic          rd_accept;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_hit;
  logic [DW-1:0] hit_data;
  wb_entry_t     head;
  wb_entry_t     push_entry;

  assign req_ready  = !fifo_full && !rd_busy;
  assign wb_empty   = fifo_empty && (state != WR_MEM);
  assign rd_accept  = req_valid && req_ready && !req_we;
  assign push       = req_valid && req_ready && req_we;
  assign pop        = (state == WR_MEM) && mem_ack;
  assign push_entry = {req_addr, req_wdata};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .lookup     (req_addr[AW-1:WOFF]),
    .hit        (fifo_hit),
    .hit_data   (hit_data),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Hit status and forwarded data are captured at accept time, so a drain
  // popping the matching entry afterwards cannot disturb the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_busy   <= 1'b0;
      rd_hit    <= 1'b0;
      rd_addr   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (rd_accept) begin
        rd_busy  <= 1'b1;
        rd_hit   <= fifo_hit;
        rd_addr  <= req_addr;
        rsp_data <= hit_data;
      end
      case (state)
        IDLE: begin
          if (rd_accept && fifo_hit) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end else if (rd_accept) begin
            state    <= RD_MEM;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= req_addr;
          end else if (rd_busy && rd_hit) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end else if (rd_busy) begin
            state    <= RD_MEM;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
          end else if (!fifo_empty) begin
            state     <= WR_MEM;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= head.addr;
            mem_wdata <= head.data;
          end
        end
        RD_MEM: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            rsp_data  <= mem_rdata;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        WR_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
          end
        end
        RSP: begin
          rd_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
